// File: rtl/fpmul_seq_if.sv
// fpmul_seq_if: handshake bundle for the sequential FP multiplier.
//   in_valid/in_ready/x/y   operand side (master drives valid + operands)
//   out_valid/out_ready/z   result side (slave drives valid + result)
//   ovf/unf                 result flags, meaningful while out_valid=1
// Operand/result format: {sign, exp[EW-1:0], mant[MW-1:0]}.
interface fpmul_seq_if #(
    parameter int EW = 4,
    parameter int MW = 7
);
    localparam int W = EW + MW + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z, ovf, unf
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z, ovf, unf
    );
endinterface

// File: rtl/fpmul_seq.sv
// fpmul_seq: multi-cycle floating-point multiplier.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   fpmul_seq_if.slave: operands x/y with in_valid/in_ready,
//         product z with ovf/unf flags and out_valid/out_ready
// Mantissas are multiplied by shift-add, one multiplier bit per cycle,
// followed by a single normalise cycle. Overflow saturates to the largest
// magnitude, underflow flushes to signed zero.
// Optional build macro FPMUL_RNE_EN: round-to-nearest-even in the normalise
// cycle; without it the mantissa is truncated.
module fpmul_seq #(
    parameter int EW   = 4,
    parameter int MW   = 7,
    parameter int BIAS = (1 << (EW - 1)) - 1
) (
    input  logic        clk,
    input  logic        rst,
    fpmul_seq_if.slave  bus
);
    localparam int W  = EW + MW + 1;
    localparam int PW = 2 * MW + 2;
    localparam int CW = $clog2(MW + 2);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   ex_q, ex_d, ey_q, ey_d;
    logic [MW:0]     a_q, a_d, b_q, b_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    z_q, z_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;

    // Normalise / round / range-check, evaluated from the finished product.
    logic            hi;
    logic [MW-1:0]   m_trunc, m_fin;
    logic [EW+1:0]   e_base, e_fin;
    logic            ovf_n, unf_n;
    logic            sgn_in;

    always_comb begin
        hi      = p_q[PW-1];
        m_trunc = hi ? p_q[2*MW -: MW] : p_q[2*MW-1 -: MW];
        // Two's complement in EW+2 bits; the top bit is the sign.
        e_base  = (EW+2)'(ex_q) + (EW+2)'(ey_q) - (EW+2)'(BIAS) + (EW+2)'(hi);
    end

`ifdef FPMUL_RNE_EN
    logic guard, sticky, rnd, carry;
    always_comb begin
        guard   = hi ? p_q[MW] : p_q[MW-1];
        sticky  = hi ? (|p_q[MW-1:0]) : (|p_q[MW-2:0]);
        rnd     = guard & (sticky | m_trunc[0]);
        {carry, m_fin} = {1'b0, m_trunc} + (MW+1)'(rnd);
        // Mantissa wrap to zero bumps the exponent before range checks.
        e_fin   = e_base + (EW+2)'(carry);
    end
`else
    logic unused_lsbs;
    assign unused_lsbs = ^p_q[MW-1:0];
    always_comb begin
        m_fin = m_trunc;
        e_fin = e_base;
    end
`endif

    // Positive and >= 2^EW means above the largest exponent field.
    assign ovf_n  = !e_fin[EW+1] && e_fin[EW];
    assign unf_n  = e_fin[EW+1] || (e_fin == '0);
    assign sgn_in = bus.x[W-1] ^ bus.y[W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ex_q    <= '0;
            ey_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        ex_d          = ex_q;
        ey_d          = ey_q;
        a_d           = a_q;
        b_d           = b_q;
        p_d           = p_q;
        cnt_d         = cnt_q;
        z_d           = z_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    sign_d = sgn_in;
                    ex_d   = bus.x[W-2:MW];
                    ey_d   = bus.y[W-2:MW];
                    a_d    = {1'b1, bus.x[MW-1:0]};
                    b_d    = {1'b1, bus.y[MW-1:0]};
                    p_d    = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    // Zero exponent field means the operand is zero.
                    if (bus.x[W-2:MW] == '0 || bus.y[W-2:MW] == '0) begin
                        z_d     = {sgn_in, {(W-1){1'b0}}};
                        state_d = DONE;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                // b_q shifts right so bit 0 is always multiplier bit cnt.
                if (b_q[0])
                    p_d = p_q + (PW'(a_q) << cnt_q);
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MW))
                    state_d = NORM;
            end
            NORM: begin
                ovf_d = ovf_n;
                unf_d = unf_n;
                if (ovf_n)
                    z_d = {sign_q, {(W-1){1'b1}}};
                else if (unf_n)
                    z_d = {sign_q, {(W-1){1'b0}}};
                else
                    z_d = {sign_q, e_fin[EW-1:0], m_fin};
                state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.z   = z_q;
    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
endmodule

// File: tb/tb_fpmul_seq.sv
// tb_fpmul_seq: scoreboard bench for fpmul_seq at default parameters.
// Expected results are queued when operands are accepted and popped when
// the unit presents its result.
module tb_fpmul_seq;
    localparam int EW   = 4;
    localparam int MW   = 7;
    localparam int BIAS = 7;
    localparam int W    = EW + MW + 1;

    typedef struct packed {
        logic [W-1:0] z;
        logic         ovf;
        logic         unf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpmul_seq_if #(.EW(EW), .MW(MW)) bus ();

    fpmul_seq #(.EW(EW), .MW(MW), .BIAS(BIAS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then normalise.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic s;
        int   ea, eb, e, prod, m, sh;
        s     = a[W-1] ^ b[W-1];
        ea    = int'(a[W-2:MW]);
        eb    = int'(b[W-2:MW]);
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.z   = {s, {(W-1){1'b0}}};
        if (ea == 0 || eb == 0) return r;
        prod = int'({1'b1, a[MW-1:0]}) * int'({1'b1, b[MW-1:0]});
        if (prod >= (1 << (2*MW+1))) begin
            sh = MW + 1;
            e  = ea + eb - BIAS + 1;
        end else begin
            sh = MW;
            e  = ea + eb - BIAS;
        end
        m = (prod >> sh) & ((1 << MW) - 1);
`ifdef FPMUL_RNE_EN
        begin
            int g, st;
            g  = (prod >> (sh - 1)) & 1;
            st = ((prod & ((1 << (sh - 1)) - 1)) != 0) ? 1 : 0;
            if (g == 1 && (st == 1 || (m & 1) == 1)) begin
                m++;
                if (m == (1 << MW)) begin
                    m = 0;
                    e++;
                end
            end
        end
`endif
        if (e > (1 << EW) - 1) begin
            r.z   = {s, {(W-1){1'b1}}};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.unf = 1'b1;
        end else begin
            r.z = {s, EW'(e), MW'(m)};
        end
        return r;
    endfunction

    // One full transaction: handshake, latency/result check, optional
    // back-pressure hold, then release and check return to idle.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input res_t exp_r, input int hold);
        int   t;
        int   lat;
        int   exp_lat;
        res_t r;
        exp_lat = (xa[W-2:MW] == '0 || ya[W-2:MW] == '0) ? 1 : MW + 2;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.x        = xa;
        bus.y        = ya;
        bus.in_valid = 1'b1;
        sb.push_back(exp_r);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x        = W'($urandom);
        bus.y        = W'($urandom);
        lat = 0;
        do begin
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 50);
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        r = sb.pop_front();
        chk("z", 32'(bus.z), 32'(r.z));
        chk("ovf", 32'(bus.ovf), 32'(r.ovf));
        chk("unf", 32'(bus.unf), 32'(r.unf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_z", 32'(bus.z), 32'(r.z));
            chk("hold_flags", 32'({bus.ovf, bus.unf}), 32'({r.ovf, r.unf}));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    res_t e;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_flags", 32'({bus.ovf, bus.unf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        e = '{z: 12'h410, ovf: 1'b0, unf: 1'b0};
        run_op(12'h3C0, 12'h3C0, e, 0);
        e = '{z: 12'h800, ovf: 1'b0, unf: 1'b0};
        run_op(12'h000, 12'hBC0, e, 0);
        e = '{z: 12'hFFF, ovf: 1'b1, unf: 1'b0};
        run_op(12'h7FF, 12'hFFF, e, 0);
        e = '{z: 12'h000, ovf: 1'b0, unf: 1'b1};
        run_op(12'h080, 12'h080, e, 0);
`ifdef FPMUL_RNE_EN
        e = '{z: 12'h3C2, ovf: 1'b0, unf: 1'b0};
`else
        e = '{z: 12'h3C1, ovf: 1'b0, unf: 1'b0};
`endif
        run_op(12'h381, 12'h3C0, e, 0);
        // Back-pressure: result held for 5 cycles.
        e = '{z: 12'h410, ovf: 1'b0, unf: 1'b0};
        run_op(12'h3C0, 12'h3C0, e, 5);

        // Abort mid-multiply; no result may appear for it.
        bus.x        = 12'h3C0;
        bus.y        = 12'h3C0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        e = '{z: 12'h410, ovf: 1'b0, unf: 1'b0};
        run_op(12'h3C0, 12'h3C0, e, 0);

        // Mixed vectors against the reference model.
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] xa, ya;
            xa = W'($urandom);
            ya = W'($urandom);
            run_op(xa, ya, model(xa, ya), i % 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpmul_seq.md
# fpmul_seq

Parametrised sequential floating-point multiplier, successor to the fixed 12-bit combinational unit. It has configurable exponent and mantissa widths, a valid/ready handshake on both sides, and a shift-add mantissa datapath driven by a small FSM. Overflow saturates and underflow flushes to zero, and both are flagged. It sits in the execute stage as a multi-cycle functional unit beside the integer ALU ops.

## Interface
- EW, 4, exponent field width (bits)
- MW, 7, stored mantissa width, hidden 1 implied
- BIAS, 2^(EW-1)-1, exponent bias (7 at defaults)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit idle, accepts operands
- x, y  in  EW+MW+1  operands; format {sign, exp[EW-1:0], mant[MW-1:0]}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  EW+MW+1  product, same format
- ovf  out  1  exponent overflow, result saturated
- unf  out  1  exponent underflow, result flushed to zero

## Operation
- States: IDLE, MUL, NORM, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready, capture sign = x.s^y.s, ex, ey, A={1,x.mant}, B={1,y.mant}, clear accumulator P (2MW+2 bits), cnt=0.
  - If either exp field ==0, the operand is zero: next state is DONE with z={sign,0}, ovf=unf=0.
  - Otherwise next state is MUL.
- MUL
  - One multiplier bit per cycle, LSB first: if B[cnt] then P += A<<cnt.
  - cnt increments; after MW+1 cycles go to NORM.
- NORM: single cycle; register z, ovf and unf, then go to DONE.
  - If P[2MW+1]: m=P[2MW:MW+1], E=ex+ey-BIAS+1. Else: m=P[2MW-1:MW], E=ex+ey-BIAS.
  - E is computed signed, EW+2 bits.
  - Rounding: see Configuration.
  - If E > 2^EW-1: z={sign, all-ones exp, all-ones mant}, ovf=1.
  - If E <= 0: z={sign, 0}, unf=1.
  - Otherwise z={sign, E[EW-1:0], m}.
- DONE
  - out_valid=1; z and flags held stable.
  - On out_ready go to IDLE.
- Only IDLE asserts in_ready; input changes outside the capture edge are ignored.
- Exp all-ones is an ordinary finite exponent; there are no inf/NaN encodings. Negative zero is preserved.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, z=0, ovf=0, unf=0, P=0, cnt=0.
- Handshake at edge T, nonzero operands: MUL at T+1..T+MW+1, NORM registers at T+MW+2. out_valid is high after edge T+MW+2 (9 cycles at defaults).
- Zero fast path: out_valid is high after edge T+1.
- The out_valid&out_ready edge returns to IDLE. in_ready rises the following cycle, so there is no same-cycle accept.
- Minimum initiation interval is MW+3 cycles (normal) or 2 cycles (zero fast path).
- out_ready low holds DONE indefinitely with z and flags stable.
- rst asserted in any state aborts the operation; no result is produced for it.
- ovf and unf are mutually exclusive and valid only while out_valid=1.

## Configuration
- FPMUL_RNE_EN defined: round to nearest even.
  - guard = bit just below m's LSB in P; sticky = OR of all lower bits.
  - Increment m if guard&(sticky|m[0]).
  - Mantissa carry-out sets m=0 and E+=1, applied before the overflow/underflow checks.
  - Latency is unchanged; rounding lives in the NORM cycle.
- Undefined: truncation; guard and sticky are ignored.

## Test plan
- Defaults, x=0x3C0 (1.5), y=0x3C0 -> after 9 cycles z=0x410 (2.25), ovf=unf=0, in_ready low throughout.
- x=0x000, y=0xBC0 -> out_valid 1 cycle after handshake, z=0x800, no flags.
- x=0x7FF, y=0xFFF -> z=0xFFF, ovf=1. Then x=y=0x080 -> z=0x000, unf=1.
- x=0x381, y=0x3C0 -> z=0x3C1 without FPMUL_RNE_EN, z=0x3C2 with it.
- Hold out_ready=0 for 5 cycles after out_valid -> z, out_valid and flags stable, in_ready=0. Release -> in_ready=1 the next cycle.
- Assert rst mid-MUL (cycle 4) -> out_valid=0, in_ready=1 immediately. A following 0x3C0*0x3C0 gives 0x410 with normal latency.
